// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and the FSM state type for the simple master.
package axi_pkg;

  // Burst type encodings
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  // Response encodings
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Largest legal size encoding on a 64-bit bus (8 bytes)
  localparam logic [2:0] MAX_SIZE = 3'd3;

  // Master transaction sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WR    = 3'd1,
    ST_WRESP = 3'd2,
    ST_RD    = 3'd3,
    ST_RDATA = 3'd4,
    ST_RSP   = 3'd5
  } sm_state_e;

endpackage

// File: rtl/axi_simple_master.sv
// Single-outstanding AXI4 initiator: turns one load/store request into one
// single-beat AXI transaction and returns one response (data + error flag).
//
// Handshake rule on every channel here: a transfer happens on the rising clock
// edge where valid and ready are both high; a valid, once raised, stays high
// with its payload unchanged until that edge, and ready may do anything.
module axi_simple_master
  import axi_pkg::*;
#(
  parameter int                     ADDR_WIDTH = 32,
  parameter int                     ID_WIDTH   = 1,
  parameter logic [ID_WIDTH-1:0]    AXI_ID     = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  // request port
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [2:0]            req_size,
  input  logic [63:0]           req_wdata,
  input  logic [7:0]            req_wstrb,
  // response port
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [63:0]           rsp_rdata,
  output logic                  rsp_err,
  // write address channel
  output logic [ID_WIDTH-1:0]   awid,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic                  awvalid,
  input  logic                  awready,
  // write data channel
  output logic [63:0]           wdata,
  output logic [7:0]            wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  // write response channel
  input  logic [ID_WIDTH-1:0]   bid,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  // read address channel
  output logic [ID_WIDTH-1:0]   arid,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic                  arvalid,
  input  logic                  arready,
  // read data channel
  input  logic [ID_WIDTH-1:0]   rid,
  input  logic [63:0]           rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready
);

  sm_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]            size_q, size_d;
  logic [63:0]           wdata_q, wdata_d;
  logic [7:0]            wstrb_q, wstrb_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic [63:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic aw_done_now;
  logic w_done_now;

  // A channel counts as done if it finished earlier or is finishing this cycle,
  // which lets WR leave on the same edge as the second handshake.
  assign aw_done_now = aw_done_q | awready;
  assign w_done_now  = w_done_q  | wready;

  // Next-state and capture logic for the transaction sequencer
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d    = req_addr;
          size_d    = req_size;
          wdata_d   = req_wdata;
          wstrb_d   = req_wstrb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = req_write ? ST_WR : ST_RD;
        end
      end
      ST_WR: begin
        aw_done_d = aw_done_now;
        w_done_d  = w_done_now;
        if (aw_done_now && w_done_now) begin
          state_d = ST_WRESP;
        end
      end
      ST_WRESP: begin
        if (bvalid) begin
          err_d   = (bresp != RESP_OKAY) | (bid != AXI_ID);
          rdata_d = '0;
          state_d = ST_RSP;
        end
      end
      ST_RD: begin
        if (arready) begin
          state_d = ST_RDATA;
        end
      end
      ST_RDATA: begin
        if (rvalid) begin
          rdata_d = rdata;
          err_d   = (rresp != RESP_OKAY) | (rid != AXI_ID) | ~rlast;
          state_d = ST_RSP;
        end
      end
      ST_RSP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and capture registers; reset abandons any in-flight transaction
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  // Handshake outputs decode straight from registered state, so nothing
  // here is combinationally dependent on a slave input.
  assign req_ready = (state_q == ST_IDLE) && !rst;
  assign awvalid   = (state_q == ST_WR) && !aw_done_q;
  assign wvalid    = (state_q == ST_WR) && !w_done_q;
  assign bready    = (state_q == ST_WRESP);
  assign arvalid   = (state_q == ST_RD);
  assign rready    = (state_q == ST_RDATA);
  assign rsp_valid = (state_q == ST_RSP);

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // Single-beat INCR transfers with a fixed ID
  assign awid    = AXI_ID;
  assign awaddr  = addr_q;
  assign awlen   = 8'd0;
  assign awsize  = size_q;
  assign awburst = BURST_INCR;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = 1'b1;
  assign arid    = AXI_ID;
  assign araddr  = addr_q;
  assign arlen   = 8'd0;
  assign arsize  = size_q;
  assign arburst = BURST_INCR;

  // Sizes above 8 bytes cannot be carried on this bus
  a_legal_size : assert property (@(posedge clk) disable iff (rst)
    (req_valid && req_ready) |-> (req_size <= MAX_SIZE));

endmodule

// File: tb/tb_axi_simple_master.sv
// Directed bench for axi_simple_master: a table of request/slave-behaviour
// records with hand-computed responses and latencies, plus reset sequences.
module tb_axi_simple_master;

  logic        clk;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr;
  logic [2:0]  req_size;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic        rsp_valid, rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  logic [0:0]  awid, bid, arid, rid;
  logic [31:0] awaddr, araddr;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic [63:0] wdata, rdata;
  logic [7:0]  wstrb;

  axi_simple_master dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- vector table ----------------
  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    int          aw_wait;
    int          w_wait;
    int          ar_wait;
    int          rsp_wait;
    logic [1:0]  bresp;
    logic        bid;
    logic [1:0]  rresp;
    logic        rid;
    logic        rlast;
    logic [63:0] rdata;
    logic [63:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[10];
  int   n_vec = 0;
  int   n_err = 0;

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t blank();
    vec_t v;
    v.write = 1'b0; v.addr = '0; v.size = 3'd3; v.wdata = '0; v.wstrb = '0;
    v.aw_wait = 0; v.w_wait = 0; v.ar_wait = 0; v.rsp_wait = 0;
    v.bresp = 2'b00; v.bid = 1'b0; v.rresp = 2'b00; v.rid = 1'b0; v.rlast = 1'b1;
    v.rdata = '0; v.exp_rdata = '0; v.exp_err = 1'b0; v.exp_lat = 3;
    return v;
  endfunction

  // ---------------- driver / slave model ----------------
  task automatic clear_slave();
    awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0; rsp_ready = 0;
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    int t, aw_seen, w_seen, ar_seen, rsp_seen;
    int aw_beats, w_beats, ar_beats, r_beats, b_beats;
    int rsp_t;
    bit done;
    logic [63:0] got_rdata;
    logic        got_err;
    v = vecs[idx];
    chk($sformatf("v%0d_idle_ready", idx), req_ready, 1);
    req_valid = 1; req_write = v.write; req_addr = v.addr; req_size = v.size;
    req_wdata = v.wdata; req_wstrb = v.wstrb;
    bresp = v.bresp; bid = v.bid; rresp = v.rresp; rid = v.rid;
    rlast = v.rlast; rdata = v.rdata;
    exp_q.push_back(v.exp_rdata);
    @(posedge clk); #1;
    req_valid = 0;
    t = 1; done = 0; rsp_t = -1;
    aw_seen = 0; w_seen = 0; ar_seen = 0; rsp_seen = 0;
    aw_beats = 0; w_beats = 0; ar_beats = 0; r_beats = 0; b_beats = 0;
    got_rdata = '0; got_err = 0;
    while (!done && t < 60) begin
      awready   = awvalid && (aw_seen >= v.aw_wait);
      wready    = wvalid && (w_seen >= v.w_wait);
      arready   = arvalid && (ar_seen >= v.ar_wait);
      bvalid    = bready;
      rvalid    = rready;
      rsp_ready = rsp_valid && (rsp_seen >= v.rsp_wait);
      chk($sformatf("v%0d_t%0d_req_ready_busy", idx, t), req_ready, 0);
      if (awvalid) begin
        chk($sformatf("v%0d_t%0d_awaddr", idx, t), awaddr, v.addr);
        chk($sformatf("v%0d_t%0d_awsize", idx, t), awsize, v.size);
      end
      if (wvalid) begin
        chk($sformatf("v%0d_t%0d_wdata", idx, t), wdata, v.wdata);
        chk($sformatf("v%0d_t%0d_wstrb", idx, t), wstrb, v.wstrb);
        chk($sformatf("v%0d_t%0d_w_after_beat", idx, t), w_beats, 0);
      end
      if (arvalid) begin
        chk($sformatf("v%0d_t%0d_araddr", idx, t), araddr, v.addr);
        chk($sformatf("v%0d_t%0d_arsize", idx, t), arsize, v.size);
      end
      if (bready)
        chk($sformatf("v%0d_t%0d_bready_early", idx, t), (aw_beats == 1) && (w_beats == 1), 1);
      if (rsp_valid) begin
        chk($sformatf("v%0d_t%0d_rsp_rdata", idx, t), rsp_rdata, v.exp_rdata);
        chk($sformatf("v%0d_t%0d_rsp_err", idx, t), rsp_err, v.exp_err);
      end
      if (awvalid) aw_seen++;
      if (wvalid) w_seen++;
      if (arvalid) ar_seen++;
      if (rsp_valid) rsp_seen++;
      if (awvalid && awready) aw_beats++;
      if (wvalid && wready) w_beats++;
      if (arvalid && arready) ar_beats++;
      if (bvalid && bready) b_beats++;
      if (rvalid && rready) r_beats++;
      if (rsp_valid && rsp_ready) begin
        done = 1; rsp_t = t; got_rdata = rsp_rdata; got_err = rsp_err;
      end
      @(posedge clk); #1;
      t++;
    end
    clear_slave();
    chk($sformatf("v%0d_completed", idx), done, 1);
    chk($sformatf("v%0d_latency", idx), rsp_t, v.exp_lat);
    chk($sformatf("v%0d_rdata", idx), got_rdata, exp_q.pop_front());
    chk($sformatf("v%0d_err", idx), got_err, v.exp_err);
    if (v.write) begin
      chk($sformatf("v%0d_aw_beats", idx), aw_beats, 1);
      chk($sformatf("v%0d_w_beats", idx), w_beats, 1);
      chk($sformatf("v%0d_b_beats", idx), b_beats, 1);
      chk($sformatf("v%0d_aw_hold", idx), aw_seen, v.aw_wait + 1);
      chk($sformatf("v%0d_w_hold", idx), w_seen, v.w_wait + 1);
      chk($sformatf("v%0d_no_ar", idx), ar_seen, 0);
    end else begin
      chk($sformatf("v%0d_ar_beats", idx), ar_beats, 1);
      chk($sformatf("v%0d_r_beats", idx), r_beats, 1);
      chk($sformatf("v%0d_ar_hold", idx), ar_seen, v.ar_wait + 1);
      chk($sformatf("v%0d_no_aw", idx), aw_seen + w_seen, 0);
    end
    // accept possible the cycle after the response handshake
    chk($sformatf("v%0d_next_ready", idx), req_ready, 1);
  endtask

  // ---------------- test ----------------
  initial begin
    // store, zero-wait slave
    vecs[0] = blank();
    vecs[0].write = 1; vecs[0].addr = 32'h1000_0008; vecs[0].wdata = 64'h1122334455667788;
    vecs[0].wstrb = 8'hFF; vecs[0].exp_lat = 3;
    // load with arready stalled 3 cycles
    vecs[1] = blank();
    vecs[1].addr = 32'h1000_0100; vecs[1].ar_wait = 3;
    vecs[1].rdata = 64'hDEADBEEF_CAFEF00D; vecs[1].exp_rdata = 64'hDEADBEEF_CAFEF00D;
    vecs[1].exp_lat = 6;
    // store, W accepted 2 cycles before AW
    vecs[2] = blank();
    vecs[2].write = 1; vecs[2].addr = 32'h1000_0010; vecs[2].wdata = 64'h0102030405060708;
    vecs[2].wstrb = 8'hFF; vecs[2].aw_wait = 2; vecs[2].w_wait = 0; vecs[2].exp_lat = 5;
    // store with SLVERR
    vecs[3] = blank();
    vecs[3].write = 1; vecs[3].addr = 32'h2000_0004; vecs[3].size = 3'd2;
    vecs[3].wdata = 64'hA5A5A5A5_00000000; vecs[3].wstrb = 8'hF0;
    vecs[3].bresp = 2'b10; vecs[3].exp_err = 1; vecs[3].exp_lat = 3;
    // load with DECERR, data still returned
    vecs[4] = blank();
    vecs[4].addr = 32'h2000_0008; vecs[4].rresp = 2'b11;
    vecs[4].rdata = 64'h0123456789ABCDEF; vecs[4].exp_rdata = 64'h0123456789ABCDEF;
    vecs[4].exp_err = 1;
    // load with missing RLAST
    vecs[5] = blank();
    vecs[5].addr = 32'h2000_0010; vecs[5].rlast = 0;
    vecs[5].rdata = 64'h55; vecs[5].exp_rdata = 64'h55; vecs[5].exp_err = 1;
    // load with wrong RID
    vecs[6] = blank();
    vecs[6].addr = 32'h2000_0018; vecs[6].rid = 1'b1;
    vecs[6].rdata = 64'hAA; vecs[6].exp_rdata = 64'hAA; vecs[6].exp_err = 1;
    // load with response backpressure for 5 cycles
    vecs[7] = blank();
    vecs[7].addr = 32'h3000_0020; vecs[7].size = 3'd1; vecs[7].rsp_wait = 5;
    vecs[7].rdata = 64'h0F0F0F0F_F0F0F0F0; vecs[7].exp_rdata = 64'h0F0F0F0F_F0F0F0F0;
    vecs[7].exp_lat = 8;
    // byte store with wrong BID, AW before W
    vecs[8] = blank();
    vecs[8].write = 1; vecs[8].addr = 32'h3000_0000; vecs[8].size = 3'd0;
    vecs[8].wdata = 64'h00000000_000000EE; vecs[8].wstrb = 8'h01; vecs[8].w_wait = 1;
    vecs[8].bid = 1'b1; vecs[8].exp_err = 1; vecs[8].exp_lat = 4;
    // fresh load after a mid-write reset
    vecs[9] = blank();
    vecs[9].addr = 32'h4000_0010; vecs[9].rdata = 64'hFEEDFACE_12345678;
    vecs[9].exp_rdata = 64'hFEEDFACE_12345678;

    rst = 1; req_valid = 0; req_write = 0; req_addr = '0; req_size = '0;
    req_wdata = '0; req_wstrb = '0;
    bid = '0; bresp = '0; rid = '0; rdata = '0; rresp = '0; rlast = 1;
    clear_slave();

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_awaddr", awaddr, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_wstrb", wstrb, 0);
    chk("const_len", {awlen, arlen}, 0);
    chk("const_burst", {awburst, arburst}, 4'b0101);
    chk("const_wlast", wlast, 1);
    chk("const_id", {awid, arid}, 0);
    rst = 0;
    #1;
    chk("post_rst_ready", req_ready, 1);

    for (int i = 0; i < 9; i++) run_vec(i);

    // reset while AW/W are outstanding
    req_valid = 1; req_write = 1; req_addr = 32'h5000_0000; req_size = 3'd3;
    req_wdata = 64'hCCCC; req_wstrb = 8'hFF;
    @(posedge clk); #1;
    req_valid = 0;
    chk("mid_awvalid_on", awvalid, 1);
    chk("mid_wvalid_on", wvalid, 1);
    rst = 1;
    #1;
    chk("mid_rst_req_ready", req_ready, 0);
    @(posedge clk); #1;
    chk("mid_rst_awvalid", awvalid, 0);
    chk("mid_rst_wvalid", wvalid, 0);
    chk("mid_rst_bready", bready, 0);
    chk("mid_rst_req_ready2", req_ready, 0);
    @(posedge clk); #1;
    rst = 0;
    #1;
    chk("mid_rst_release_ready", req_ready, 1);
    run_vec(9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axi_simple_master.md
Name: axi_simple_master

Overview:
- Single-outstanding AXI4 initiator. Converts a simple valid/ready load/store request port, driven by a core LSU or a debug DMA, into single-beat AXI4 transactions on a 64-bit data bus.
- It is the initiator-side counterpart to the peripheral AXI slaves (UART, GPIO) and connects to the interconnect master port.
- It returns one response per request: read data plus an error flag.

Parameters:
- ADDR_WIDTH, 32, width of request and AXI addresses.
- ID_WIDTH, 1, width of AXI ID fields. Must be ≥1.
- AXI_ID, 0, constant ID driven on AWID and ARID.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid&ready
- req_write  in  1  1=store, 0=load
- req_addr  in  ADDR_WIDTH  byte address
- req_size  in  3  AXI size encoding, 0..3
- req_wdata  in  64  store data, lane-aligned
- req_wstrb  in  8  store byte strobes
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_rdata  out  64  load data; 0 for stores
- rsp_err  out  1  SLVERR/DECERR, ID mismatch or missing RLAST
- awid/awaddr/awlen/awsize/awburst/awvalid  out  ID_WIDTH/ADDR_WIDTH/8/3/2/1
- awready  in  1
- wdata/wstrb/wlast/wvalid  out  64/8/1/1
- wready  in  1
- bid/bresp/bvalid  in  ID_WIDTH/2/1
- bready  out  1
- arid/araddr/arlen/arsize/arburst/arvalid  out  ID_WIDTH/ADDR_WIDTH/8/3/2/1
- arready  in  1
- rid/rdata/rresp/rlast/rvalid  in  ID_WIDTH/64/2/1/1
- rready  out  1

Behaviour:
- Reset (synchronous on rst=1): state IDLE; all *valid, bready, rready and rsp_valid = 0; rsp_rdata = 0; rsp_err = 0; address, data and strobe registers = 0.
- Constant outputs: awlen = arlen = 0; awburst = arburst = 2'b01 (INCR); wlast = 1; awid = arid = AXI_ID.
- req_ready = 1 only in IDLE. The request is captured into registers on the handshake.
- States: IDLE, WR, WRESP, RD, RDATA, RSP.
- IDLE --req & write--> WR. Next cycle awvalid = wvalid = 1, driven from registers.
- IDLE --req & !write--> RD. Next cycle arvalid = 1.
- WR: awvalid and wvalid drop independently on their own handshakes, tracked by aw_done and w_done flags. Both are allowed in the same cycle. When both are done (including the cycle the second completes) → WRESP. A valid is never deasserted before its ready.
- WRESP: bready = 1. On bvalid: err = (bresp != 0) | (bid != AXI_ID); rdata = 0 → RSP.
- RD: hold arvalid until arready → RDATA.
- RDATA: rready = 1. On rvalid: capture rdata; err = (rresp != 0) | (rid != AXI_ID) | !rlast → RSP.
- RSP: rsp_valid = 1, with rsp_rdata and rsp_err stable. On rsp_ready → IDLE. req_ready rises the following cycle (no same-cycle bypass).
- Minimum latency with zero-wait slave and rsp_ready tied high:
  - store: request accept at T0, AW/W at T1, B at T2, rsp_valid at T3, next accept at T4.
  - load: same, with AR at T1 and R at T2.
- No timeout; a hung slave holds the FSM indefinitely.
- Mid-operation rst: all valids and readies deassert the following cycle and any in-flight transaction is abandoned. This is acceptable because rst is system-wide.
- req_size is passed through unchanged to awsize/arsize. Values > 3 are illegal, and an assertion flags them in simulation.
- Address alignment is not checked; the slave reports errors.

Decomposition:
- Package axi_pkg holds:
  - burst encodings (INCR = 2'b01)
  - resp encodings (OKAY, EXOKAY, SLVERR, DECERR)
  - FSM state enum for this block
- No sub-module. A single FSM plus capture registers, roughly 200 lines.

Test Plan:
- Store, zero-wait slave: addr 0x1000_0008, wdata 0x1122334455667788, wstrb 0xFF, size 3 → AW/W at T1 with awaddr 0x10000008; rsp_valid at T3; rsp_err = 0; rsp_rdata = 0.
- Load with 3-cycle arready stall and rdata 0xDEADBEEF_CAFEF00D → arvalid held with araddr stable for 4 cycles; rsp_rdata = 0xDEADBEEFCAFEF00D; err = 0.
- Store with wready asserted 2 cycles before awready → wvalid drops after its handshake, awvalid held until awready; exactly one W beat; bready rises only after both handshakes complete.
- Error paths, each → rsp_err = 1:
  - bresp = 2'b10
  - rresp = 2'b11
  - rlast = 0 on the read beat
  - rid = AXI_ID ^ 1
- Response backpressure: rsp_ready low for 5 cycles → rsp_valid and data held stable, req_ready = 0 throughout; accept occurs the cycle after rsp_ready.
- rst asserted while in WR with awvalid = 1 → next cycle awvalid = wvalid = 0, req_ready = 0 during reset; after release req_ready = 1 and a fresh load completes normally.
